pipe_addsub_ripple: RTL
=======================

Name: pipe_addsub_ripple

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the fixed 32-bit pipelined ripple adder.
- Splits a BW-bit add/sub into STAGES carry-chained segments, one segment per register stage.
- Adds a valid/ready handshake with backpressure and a per-transaction add/subtract mode.
- Sits in the datapath wherever a wide, high-Fmax adder with flow control is needed.

Parameters:
- BW, 32, operand/result width in bits.
- STAGES, 4, number of pipeline segments. Must divide BW exactly; 1 <= STAGES <= BW. SEG = BW/STAGES bits per segment.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  BW  operand A, unsigned or two's complement.
- B  input  BW  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  BW  result.
- cout  output  1  carry-out of the MSB. In subtract mode, 1 means no borrow.

Behaviour:
- Reset (async, RESET=1): all stage valid bits clear; out_valid=0, sum=0, cout=0 (ovf=0 if enabled). in_ready=1 as soon as RESET deasserts.
- Advance enable: adv = ~out_valid | out_ready. One global stall for all stages. in_ready = adv, combinational.
- Accept: in_valid & in_ready.
- Stage 0 on accept:
  - Computes segment 0 (bits SEG-1:0) with effective B = sub ? ~B : B and carry-in = sub ? 1 : cin.
  - Registers upper operand segments (B already conditionally inverted), the partial sum and the segment carry.
- Stage k (1..STAGES-1): adds segment k using the carry registered by stage k-1. Lower result bits pass through registers (deskew).
- Latency: exactly STAGES cycles from accept to out_valid when unstalled. Throughput: 1 beat/cycle.
- Bubbles: when adv=1 and a stage holds no valid beat, the bubble propagates. Valid bits shift with data. A bubble may not overwrite a held beat.
- Stall (adv=0): every stage register, including sum/cout/out_valid, holds its value. No beat is dropped or duplicated.
- Output handshake: a beat completes when out_valid & out_ready. sum/cout remain stable while out_valid=1 and out_ready=0.
- Simultaneous input accept and output drain in one cycle: both occur; the pipeline shifts by one.
- Wrap-around: the result is mod 2^BW; the carry is reported only on cout.
- STAGES=1: purely a registered adder with latency 1.
- RESET mid-operation: all in-flight beats are discarded; no out_valid pulse follows.
- Inputs are sampled only on accept; A/B/cin/sub are don't-care otherwise.

Optional Feature:
- Macro: PIPE_ADDSUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), meaning signed two's-complement overflow of the beat on sum.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
  - Registered, stalled and reset identically to cout.
- Undefined: no ovf port and no related logic.

Test Plan (BW=32, STAGES=4 unless noted):
1. Streaming add: A=30000, B=50000, cin=0, sub=0, in_valid held, out_ready=1 -> sum=80000, cout=0, out_valid high exactly 4 cycles after accept; back-to-back beats A+=30000, B+=50000 yield one result per cycle in order.
2. Full carry ripple: A=0xFFFFFFFF, B=0, cin=1 -> sum=0, cout=1. Repeat with STAGES=1 and STAGES=32 -> same result, latencies 1 and 32.
3. Subtract: A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0. A=7, B=5, sub=1, cin=1 -> sum=2, cout=1 (cin ignored).
4. Backpressure: 6 beats streamed while out_ready is low for 5 cycles starting at the first out_valid -> in_ready drops the same cycle; sum holds stable; all 6 results appear in order after release with no loss or duplication.
5. Reset mid-flight: 3 beats accepted, RESET pulsed 1 cycle asynchronously (between edges) -> out_valid=0, sum=0 immediately; no stale result appears afterwards; the next beat has latency 4.
6. With PIPE_ADDSUB_OVF_EN:
   - 0x7FFFFFFF+1 -> ovf=1, cout=0.
   - 0x80000000-1 (sub) -> ovf=1, sum=0x7FFFFFFF.
   - 0xFFFFFFFF+1 -> ovf=0, cout=1.

Source files
------------

// File: rtl/pipe_addsub_ripple.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub_ripple
//  Description : Parametrised pipelined ripple-carry adder/subtractor with a
//                valid/ready handshake and a single global stall. The BW-bit
//                operation is split into STAGES carry-chained segments of
//                SEG = BW/STAGES bits, one segment resolved per register stage.
//                Optional macro PIPE_ADDSUB_OVF_EN adds a registered signed
//                overflow output (ovf).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub_ripple #(
    parameter int BW     = 32,
    parameter int STAGES = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic          cin,
    input  logic          sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] sum,
    output logic          cout
`ifdef PIPE_ADDSUB_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam int SEG = BW / STAGES;

    // One advance enable for the whole pipe: move whenever the output slot
    // is empty or is being drained this cycle.
    logic          w_adv;
    logic [BW-1:0] w_b_eff;
    logic          w_c0;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // Subtraction is A + ~B + 1; cin is ignored in subtract mode.
    assign w_b_eff  = sub ? ~B : B;
    assign w_c0     = sub | cin;

    // Stage k consumes operand bits from its own segment upward (IN_W bits),
    // forwards the still-unused upper operand bits, and extends the partial
    // result to LO_W bits. Only operand bits that a later stage reads are
    // registered, so the register count shrinks along the pipe.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = BW - k * SEG;
        localparam int LO_W = (k + 1) * SEG;

        logic [IN_W-1:0] w_a_in;
        logic [IN_W-1:0] w_b_in;
        logic            w_c_in;
        logic            w_v_in;
        logic [SEG:0]    w_add;
        logic [LO_W-1:0] w_s_next;

        logic [LO_W-1:0] r_s;
        logic            r_c;
        logic            r_v;

        if (k == 0) begin : g_first
            assign w_a_in   = A;
            assign w_b_in   = w_b_eff;
            assign w_c_in   = w_c0;
            assign w_v_in   = in_valid;
            assign w_s_next = w_add[SEG-1:0];
        end else begin : g_chain
            assign w_a_in   = g_stage[k-1].g_fwd.r_a_hi;
            assign w_b_in   = g_stage[k-1].g_fwd.r_b_hi;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_v_in   = g_stage[k-1].r_v;
            assign w_s_next = {w_add[SEG-1:0], g_stage[k-1].r_s};
        end

        // Segment adder: SEG bits plus the carry arriving from below.
        assign w_add = {1'b0, w_a_in[SEG-1:0]}
                     + {1'b0, w_b_in[SEG-1:0]}
                     + {{SEG{1'b0}}, w_c_in};

        // Valid shifts on every advance; data only loads behind a valid beat,
        // so a bubble never overwrites a held result.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                r_v <= 1'b0;
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_v_in;
                if (w_v_in) begin
                    r_s <= w_s_next;
                    r_c <= w_add[SEG];
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-SEG-1:0] r_a_hi;
            logic [IN_W-SEG-1:0] r_b_hi;

            // Upper operand segments travel alongside the beat (deskew).
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_adv && w_v_in) begin
                    r_a_hi <= w_a_in[IN_W-1:SEG];
                    r_b_hi <= w_b_in[IN_W-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;

`ifdef PIPE_ADDSUB_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
    logic w_msb_cin;
    logic r_ovf;

    assign w_msb_cin = g_stage[STAGES-1].w_a_in[SEG-1]
                     ^ g_stage[STAGES-1].w_b_in[SEG-1]
                     ^ g_stage[STAGES-1].w_add[SEG-1];

    // Overflow flag is captured, held and cleared exactly like cout.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ovf <= 1'b0;
        end else if (w_adv && g_stage[STAGES-1].w_v_in) begin
            r_ovf <= w_msb_cin ^ g_stage[STAGES-1].w_add[SEG];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire
